// File: rtl/axi_stream_checker_if.sv
// axi_stream_checker_if: AXI4-Stream bundle; monitor modport taps every signal as an input.
// Zero-width TID/TDEST/TUSER collapse to an unused 1-bit signal.
interface axi_stream_checker_if #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 0,
    parameter int DEST_WIDTH = 0,
    parameter int USER_WIDTH = 0
);
    localparam int IW = ID_WIDTH > 0 ? ID_WIDTH : 1;
    localparam int DW = DEST_WIDTH > 0 ? DEST_WIDTH : 1;
    localparam int UW = USER_WIDTH > 0 ? USER_WIDTH : 1;
    logic                    tvalid;
    logic                    tready;
    logic [8*BYTE_WIDTH-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tstrb;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic                    tlast;
    logic [IW-1:0]           tid;
    logic [DW-1:0]           tdest;
    logic [UW-1:0]           tuser;
    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
    modport monitor (input tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser);
endinterface

// File: rtl/axi_stream_checker.sv
// axi_stream_checker: passive AXI4-Stream protocol checker with sticky error flags and saturating counters.
// Define AXIS_CHECKER_WATCHDOG_EN to build the stall watchdog that drives err_flags[5].
module axi_stream_checker #(
    parameter int BYTE_WIDTH          = 4,
    parameter int ID_WIDTH            = 0,
    parameter int DEST_WIDTH          = 0,
    parameter int USER_WIDTH          = 0,
    parameter int MAX_PKT_BEATS       = 0,
    parameter int CHECK_NO_INTERLEAVE = 1,
    parameter int STALL_LIMIT         = 1024,
    parameter int COUNT_W             = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    axi_stream_checker_if.monitor  axis,
    output logic [6:0]             err_flags,
    output logic                   err_any,
    output logic [COUNT_W-1:0]     beat_count,
    output logic [COUNT_W-1:0]     byte_count,
    output logic [COUNT_W-1:0]     packet_count,
    output logic                   in_packet
);
    localparam int IW = ID_WIDTH > 0 ? ID_WIDTH : 1;
    localparam int DW = DEST_WIDTH > 0 ? DEST_WIDTH : 1;
    localparam int UW = USER_WIDTH > 0 ? USER_WIDTH : 1;
    localparam int PW = 10 * BYTE_WIDTH + 1 + IW + DW + UW;
    localparam logic [0:0] IDLE = 1'b0, IN_PKT = 1'b1;

    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a, input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNT_W] ? '1 : s[COUNT_W-1:0];
    endfunction

    logic [0:0]         state;
    logic [COUNT_W-1:0] pkt_beats;
    logic [IW-1:0]      lat_id;
    logic [DW-1:0]      lat_dest;
    logic               prev_valid, prev_ready, armed, stall_hit;
    logic [PW-1:0]      prev_payload;
    logic [6:0]         err_det, err_next;
    // absent sideband fields are masked to zero so they never register as a change
    wire                hs      = axis.tvalid & axis.tready;
    wire  [IW-1:0]      tid_m   = ID_WIDTH > 0 ? axis.tid : '0;
    wire  [DW-1:0]      tdest_m = DEST_WIDTH > 0 ? axis.tdest : '0;
    wire  [UW-1:0]      tuser_m = USER_WIDTH > 0 ? axis.tuser : '0;
    wire  [PW-1:0]      payload = {axis.tdata, axis.tstrb, axis.tkeep, axis.tlast, tid_m, tdest_m, tuser_m};
    wire  [COUNT_W-1:0] keep_pop = COUNT_W'($countones(axis.tkeep));
    wire                stalled = prev_valid & ~prev_ready;

`ifdef AXIS_CHECKER_WATCHDOG_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stall_cnt;
    wire           stall = axis.tvalid & ~axis.tready;
    assign stall_hit = stall && stall_cnt == SW'(STALL_LIMIT - 1);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) stall_cnt <= '0;
        else stall_cnt <= !stall ? '0 : stall_cnt == SW'(STALL_LIMIT) ? stall_cnt : stall_cnt + 1'b1;
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        err_det[0] = stalled & ~axis.tvalid;
        err_det[1] = stalled & axis.tvalid & (payload != prev_payload);
        err_det[2] = axis.tvalid & |(axis.tstrb & ~axis.tkeep);
        err_det[3] = MAX_PKT_BEATS > 0 && hs && state == IN_PKT && pkt_beats == COUNT_W'(MAX_PKT_BEATS) && !axis.tlast;
        err_det[4] = CHECK_NO_INTERLEAVE != 0 && hs && state == IN_PKT &&
                     ((ID_WIDTH > 0 && tid_m != lat_id) || (DEST_WIDTH > 0 && tdest_m != lat_dest));
        err_det[5] = stall_hit;
        err_det[6] = ~armed & axis.tvalid;
        err_next   = (clear ? 7'd0 : err_flags) | err_det;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pkt_beats    <= '0;
            lat_id       <= '0;
            lat_dest     <= '0;
            prev_valid   <= 1'b0;
            prev_ready   <= 1'b0;
            prev_payload <= '0;
            armed        <= 1'b0;
            err_flags    <= '0;
            err_any      <= 1'b0;
            beat_count   <= '0;
            byte_count   <= '0;
            packet_count <= '0;
        end else begin
            prev_valid   <= axis.tvalid;
            prev_ready   <= axis.tready;
            prev_payload <= payload;
            armed        <= 1'b1;
            err_flags    <= err_next;
            err_any      <= |err_next;
            beat_count   <= sat_add(clear ? '0 : beat_count, COUNT_W'(hs));
            byte_count   <= sat_add(clear ? '0 : byte_count, hs ? keep_pop : '0);
            packet_count <= sat_add(clear ? '0 : packet_count, COUNT_W'(hs & axis.tlast));
            if (hs && state == IDLE && !axis.tlast) begin
                state     <= IN_PKT;
                pkt_beats <= COUNT_W'(1);
                lat_id    <= tid_m;
                lat_dest  <= tdest_m;
            end else if (hs && state == IN_PKT) begin
                pkt_beats <= sat_add(pkt_beats, COUNT_W'(1));
                state     <= axis.tlast ? IDLE : IN_PKT;
            end
        end
    end

    assign in_packet = state[0];
endmodule

// File: tb/tb_axi_stream_checker.sv
// tb_axi_stream_checker: directed and randomized checks against a per-beat behavioural model.
// Expectations for err_flags[5] follow AXIS_CHECKER_WATCHDOG_EN.
module tb_axi_stream_checker;
    localparam int  MAXP  = 4;
    localparam int  STALL = 8;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0, resetn = 1'b0, clear = 1'b0;
    logic [6:0]  err_flags;
    logic        err_any, in_packet;
    logic [31:0] beat_count, byte_count, packet_count;
    int          errors = 0, checks = 0;

    axi_stream_checker_if #(.BYTE_WIDTH(4), .ID_WIDTH(2)) axis ();

    axi_stream_checker #(.BYTE_WIDTH(4), .ID_WIDTH(2), .MAX_PKT_BEATS(MAXP), .STALL_LIMIT(STALL)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .axis(axis),
        .err_flags(err_flags), .err_any(err_any), .beat_count(beat_count),
        .byte_count(byte_count), .packet_count(packet_count), .in_packet(in_packet)
    );

    always #5 clk = ~clk;

    // model state: totals as plain integers, packet tracked by length and first id
    longint      m_beats, m_bytes, m_pkts;
    bit          m_in, m_first;
    int          m_len, m_run;
    logic [1:0]  m_id;
    logic [6:0]  m_flags;
    bit          pv, pr, pl;
    logic [31:0] pd;
    logic [3:0]  ps, pk;
    logic [1:0]  pid;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(longint x);
        return x > CMAX ? CMAX : x;
    endfunction

    task automatic model_reset();
        m_beats = 0; m_bytes = 0; m_pkts = 0; m_in = 0; m_len = 0; m_run = 0; m_id = 0;
        m_flags = 0; m_first = 1; pv = 0; pr = 0; pl = 0; pd = 0; ps = 0; pk = 0; pid = 0;
    endtask

    task automatic model_edge();
        logic [6:0] det;
        bit v, r, hs;
        v = axis.tvalid; r = axis.tready; hs = v && r;
        det = 0;
        if (pv && !pr && !v) det[0] = 1;
        if (pv && !pr && v && {axis.tdata, axis.tstrb, axis.tkeep, axis.tlast, axis.tid} != {pd, ps, pk, pl, pid}) det[1] = 1;
        if (v && (axis.tstrb & ~axis.tkeep) != 0) det[2] = 1;
        if (hs && m_in && m_len == MAXP && !axis.tlast) det[3] = 1;
        if (hs && m_in && axis.tid != m_id) det[4] = 1;
        m_run = (v && !r) ? m_run + 1 : 0;
`ifdef AXIS_CHECKER_WATCHDOG_EN
        if (m_run == STALL) det[5] = 1;
`endif
        if (m_first && v) det[6] = 1;
        if (clear) begin m_beats = 0; m_bytes = 0; m_pkts = 0; m_flags = 0; end
        m_flags |= det;
        if (hs) begin
            m_beats = sat(m_beats + 1);
            m_bytes = sat(m_bytes + $countones(axis.tkeep));
            if (axis.tlast) m_pkts = sat(m_pkts + 1);
            if (m_in) begin
                m_len++;
                if (axis.tlast) m_in = 0;
            end else if (!axis.tlast) begin
                m_in = 1; m_len = 1; m_id = axis.tid;
            end
        end
        pv = v; pr = r; pd = axis.tdata; ps = axis.tstrb; pk = axis.tkeep; pl = axis.tlast; pid = axis.tid;
        m_first = 0;
    endtask

    task automatic compare_all();
        check("err_flags", err_flags, m_flags);
        check("err_any", err_any, |m_flags);
        check("beat_count", beat_count, m_beats);
        check("byte_count", byte_count, m_bytes);
        check("packet_count", packet_count, m_pkts);
        check("in_packet", in_packet, m_in);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    task automatic idle();
        axis.tvalid = 0; axis.tready = 0; axis.tdata = 0; axis.tstrb = 0; axis.tkeep = 0;
        axis.tlast = 0; axis.tid = 0; axis.tdest = 0; axis.tuser = 0; clear = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic beat(logic [31:0] d, logic [3:0] k, logic last, logic [1:0] id);
        axis.tvalid = 1; axis.tready = 1; axis.tdata = d; axis.tkeep = k; axis.tstrb = k;
        axis.tlast = last; axis.tid = id;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        // reset release with tvalid high
        axis.tvalid = 1;
        do_reset();
        tick();
        check("rst_valid_flags", err_flags, 7'b1000000);
        idle();
        do_reset();
        tick();
        check("rst_quiet_flags", err_flags, 7'd0);
        check("rst_quiet_beats", beat_count, 0);
        // three-beat packet
        beat(32'h1, 4'hF, 0, 1);
        check("pkt_in_b1", in_packet, 1);
        beat(32'h2, 4'hF, 0, 1);
        beat(32'h3, 4'h3, 1, 1);
        check("pkt_beats", beat_count, 3);
        check("pkt_bytes", byte_count, 10);
        check("pkt_count", packet_count, 1);
        check("pkt_in_b3", in_packet, 0);
        check("pkt_err", err_flags, 0);
        idle(); tick();
        // payload change while stalled
        axis.tvalid = 1; axis.tdata = 32'hA5A5A5A5; axis.tkeep = 4'hF; axis.tstrb = 4'hF;
        tick();
        axis.tdata = 32'h5A5A5A5A;
        tick();
        check("payload_change", err_flags[1], 1);
        idle(); do_reset();
        axis.tvalid = 1; axis.tkeep = 4'hF;
        tick();
        axis.tvalid = 0;
        tick();
        check("valid_drop", err_flags[0], 1);
        idle(); do_reset();
        // too-long packet, then interleave
        for (int i = 0; i < 5; i++) beat(i, 4'hF, 0, 0);
        check("pkt_too_long", err_flags[3], 1);
        check("no_interleave", err_flags[4], 0);
        beat(32'h9, 4'hF, 1, 0);
        idle(); do_reset();
        beat(32'h1, 4'hF, 0, 1);
        beat(32'h2, 4'hF, 0, 2);
        check("interleave", err_flags[4], 1);
        idle(); do_reset();
        // watchdog
        axis.tvalid = 1; axis.tkeep = 4'hF; axis.tstrb = 4'hF;
        for (int i = 0; i < STALL - 1; i++) tick();
        axis.tready = 1; axis.tlast = 1;
        tick();
        check("stall_short", err_flags[5], 0);
        axis.tready = 0;
`ifdef AXIS_CHECKER_WATCHDOG_EN
        for (int i = 0; i < STALL; i++) tick();
        check("stall_trip", err_flags[5], 1);
`else
        for (int i = 0; i < 100; i++) tick();
        check("stall_nowd", err_flags[5], 0);
`endif
        idle(); do_reset();
        // clear with hs and a strobe-without-keep beat
        beat(32'h1, 4'hF, 1, 0);
        axis.tready = 0;
        tick();
        axis.tvalid = 0;
        tick();
        check("pre_clear_drop", err_flags[0], 1);
        axis.tvalid = 1; axis.tready = 1; axis.tstrb = 4'h1; axis.tkeep = 4'h0; axis.tlast = 1; clear = 1;
        tick();
        check("clear_beats", beat_count, 1);
        check("clear_flags", err_flags, 7'b0000100);
        check("clear_bytes", byte_count, 0);
        idle();
        // reset mid-packet
        beat(32'h7, 4'hF, 0, 0);
        check("mid_pkt_in", in_packet, 1);
        idle();
        do_reset();
        check("mid_pkt_rst", in_packet, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin idle(); do_reset(); end
            if (!(axis.tvalid && !axis.tready && $urandom_range(0, 9) != 0)) begin
                axis.tvalid = $urandom_range(0, 3) != 0;
                axis.tdata  = $urandom;
                axis.tkeep  = 4'($urandom);
                axis.tstrb  = $urandom_range(0, 15) == 0 ? 4'($urandom) : axis.tkeep & 4'($urandom);
                axis.tlast  = $urandom_range(0, 3) == 0;
                if ($urandom_range(0, 9) == 0) axis.tid = 2'($urandom);
            end
            axis.tready = $urandom_range(0, 3) != 0;
            axis.tuser  = 1'($urandom);
            axis.tdest  = 1'($urandom);
            clear       = $urandom_range(0, 49) == 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_stream_checker.md
# axi_stream_checker

Synthesizable, parametrised AXI4-Stream protocol checker and traffic counter. It replaces formal-only property checking with registered, sticky error flags plus beat, byte and packet counters. It sits passively on any AXI-Stream link, taps every signal as an input, and drives nothing onto the bus. It is usable in silicon, in simulation benches and under formal tools.

## Interface
Parameters:
- `BYTE_WIDTH`, 4: TDATA width in bytes; TKEEP/TSTRB are `BYTE_WIDTH` bits.
- `ID_WIDTH`, 0: TID width; 0 means no TID; the port is 1 bit and ignored.
- `DEST_WIDTH`, 0: TDEST width; 0 means no TDEST; the port is 1 bit and ignored.
- `USER_WIDTH`, 0: TUSER width; 0 means no TUSER; the port is 1 bit and ignored.
- `MAX_PKT_BEATS`, 0: maximum beats per packet; 0 disables the length check.
- `CHECK_NO_INTERLEAVE`, 1: when 1, TID/TDEST must be constant within a packet.
- `STALL_LIMIT`, 1024: consecutive stalled cycles that trip the watchdog (≥1).
- `COUNT_W`, 32: width of the counters.

Ports:
- `clk`  in  1  sole clock; everything samples on the rising edge.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `clear`  in  1  synchronous clear of counters and error flags.
- `tvalid`, `tready`  in  1 each  monitored handshake.
- `tdata`  in  8*BYTE_WIDTH  monitored data.
- `tstrb`, `tkeep`  in  BYTE_WIDTH each  monitored byte qualifiers.
- `tlast`  in  1  monitored packet boundary.
- `tid`, `tdest`, `tuser`  in  max(W,1) each  monitored sideband.
- `err_flags`  out  7  sticky error bits, defined below.
- `err_any`  out  1  OR of `err_flags`, registered.
- `beat_count`  out  COUNT_W  handshakes seen.
- `byte_count`  out  COUNT_W  sum of popcount(tkeep) over handshakes.
- `packet_count`  out  COUNT_W  handshakes with tlast=1.
- `in_packet`  out  1  1 between the first beat and the tlast beat of a packet.

## Operation
- Handshake: hs = tvalid && tready.
- Registered copies of the previous cycle's inputs hold prev_valid, prev_ready and prev_payload. They reset to 0.
- Packet FSM has two states, IDLE and IN_PKT:
  - IDLE to IN_PKT on hs with tlast=0. On this transition, pkt_beats is set to 1 and the first beat's tid/tdest are latched.
  - IN_PKT increments pkt_beats on each hs.
  - IN_PKT to IDLE on hs with tlast=1.
  - An hs with tlast=1 while in IDLE is a one-beat packet; the FSM stays in IDLE.
- Error bits. Each is set on the edge that samples the violation and holds until reset or `clear`.
  - [0] VALID_DROP: prev_valid && !prev_ready && !tvalid.
  - [1] PAYLOAD_CHANGE: prev_valid && !prev_ready && tvalid && the payload differs from prev_payload. Payload covers tdata, tstrb, tkeep, tlast, and tid/tdest/tuser when their widths are nonzero.
  - [2] STRB_NO_KEEP: tvalid && (tstrb & ~tkeep) != 0.
  - [3] PKT_TOO_LONG: hs in IN_PKT with pkt_beats == MAX_PKT_BEATS and tlast=0. Only active when MAX_PKT_BEATS > 0.
  - [4] INTERLEAVE: hs in IN_PKT whose tid/tdest differ from the latched values. Only active when CHECK_NO_INTERLEAVE=1 and the corresponding width is > 0.
  - [5] STALL_TIMEOUT: watchdog, described under Configuration.
  - [6] RESET_VALID: tvalid=1 at the first rising edge after resetn deasserts.
- Counters increment on hs and saturate at all-ones; they never wrap. byte_count adds popcount(tkeep), in the range 0..BYTE_WIDTH.
- `clear`:
  - Zeroes the counters, then adds the current cycle's hs contribution, so clear with hs gives beat_count=1.
  - Zeroes err_flags, except that an error detected in the same cycle is still set.
  - Does not affect the packet FSM, pkt_beats or prev-state registers.
- Reset: resetn=0 asynchronously forces all outputs, counters, the FSM (to IDLE), pkt_beats, the watchdog and the prev registers to 0. No error can be recorded while in reset.
- A packet interrupted by reset is discarded; no error is raised for it.

## Timing
- Zero-cycle observation. A violation or hs sampled at edge k is visible on the outputs immediately after edge k.
- err_any is registered from the next-state error flags, so it is aligned with err_flags.
- in_packet equals the FSM state (IN_PKT=1) and updates on the same edge as the hs.
- No back-pressure and no combinational path from monitored inputs to outputs.

## Configuration
- `AXIS_CHECKER_WATCHDOG_EN` defined:
  - A stall counter, saturating at STALL_LIMIT, increments on each cycle with tvalid && !tready.
  - It clears on tready=1 or tvalid=0.
  - err_flags[5] is set on the edge where the counter reaches STALL_LIMIT.
- Not defined: no counter logic exists, and err_flags[5] is constant 0.

## Test plan
- Reset release with tvalid=1 sampled at the first edge → err_flags=7'b1000000. Reset release with tvalid=0 → all outputs 0.
- BYTE_WIDTH=4, packet of 3 beats with tkeep=F,F,3 and tlast on beat 3 → beat_count=3, byte_count=10, packet_count=1, in_packet high from the beat-1 edge to the beat-3 edge, err_flags=0.
- tvalid=1 and tready=0 for 2 cycles; tdata changes 0xA5A5A5A5 → 0x5A5A5A5A in cycle 2 → err_flags[1]=1. Separately, tvalid drops before tready → err_flags[0]=1.
- MAX_PKT_BEATS=4 with a 5th hs and no tlast → err_flags[3]=1. With ID_WIDTH=2: tid 1 on beat 1, then tid 2 on beat 2 → err_flags[4]=1.
- Watchdog build, STALL_LIMIT=8: stall for 7 cycles then tready=1 → no error. Stall for 8 cycles → err_flags[5]=1. Without the macro, a 100-cycle stall → err_flags[5]=0.
- clear asserted together with an hs and a tstrb=1,tkeep=0 beat → beat_count=1, err_flags=7'b0000100. resetn dropped mid-packet → in_packet=0 immediately and all counters 0.
